// File: rtl/tl_tx_builder.sv
// tl_tx_builder: arbitrates MWr/MRd requests and CplD completions onto a 32-bit TLP DW stream
module tl_tx_builder #(
    parameter int          TAG_W        = 8,
    parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_is_wr_i,
    input  logic [31:0]      req_addr_i,
    input  logic [9:0]       req_len_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic [31:0]      wr_data_i,
    input  logic             wr_data_valid_i,
    output logic             wr_data_ready_o,
    input  logic             cpl_valid_i,
    output logic             cpl_ready_o,
    input  logic [TAG_W-1:0] cpl_tag_i,
    input  logic [15:0]      cpl_req_id_i,
    input  logic [9:0]       cpl_len_i,
    input  logic [6:0]       cpl_lower_addr_i,
    input  logic [31:0]      cpl_data_i,
    input  logic             cpl_data_valid_i,
    output logic             cpl_data_ready_o,
    output logic [31:0]      tx_data_o,
    output logic             tx_sop_o,
    output logic             tx_eop_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i
);
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, PAYLOAD} state_t;
    state_t      state_q, state_d;
    logic        prio_cpl_q, prio_cpl_d;
    logic        src_cpl_q, src_cpl_d;
    logic        wr_q, wr_d;
    logic [9:0]  len_q, len_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [7:0]  tag_q, tag_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] rid_q, rid_d;
    logic [6:0]  la_q, la_d;
    logic        grant_cpl, grant_req, has_payload, src_valid;

    assign grant_cpl   = rst_n && state_q == IDLE && cpl_valid_i && (!req_valid_i || prio_cpl_q);
    assign grant_req   = rst_n && state_q == IDLE && req_valid_i && !grant_cpl;
    assign has_payload = src_cpl_q || wr_q;
    assign src_valid   = src_cpl_q ? cpl_data_valid_i : wr_data_valid_i;

    // Next-state, header capture and tx/ready outputs; everything is forced idle while in reset
    always_comb begin
        state_d          = state_q;
        prio_cpl_d       = prio_cpl_q;
        src_cpl_d        = src_cpl_q;
        wr_d             = wr_q;
        len_d            = len_q;
        cnt_d            = cnt_q;
        tag_d            = tag_q;
        addr_d           = addr_q;
        rid_d            = rid_q;
        la_d             = la_q;
        req_ready_o      = 1'b0;
        cpl_ready_o      = 1'b0;
        wr_data_ready_o  = 1'b0;
        cpl_data_ready_o = 1'b0;
        tx_data_o        = 32'h0;
        tx_sop_o         = 1'b0;
        tx_eop_o         = 1'b0;
        tx_valid_o       = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    req_ready_o = grant_req;
                    cpl_ready_o = grant_cpl;
                    if (grant_cpl || grant_req) begin
                        state_d   = HDR0;
                        src_cpl_d = grant_cpl;
                        wr_d      = grant_req && req_is_wr_i;
                        len_d     = grant_cpl ? cpl_len_i : req_len_i;
                        cnt_d     = grant_cpl ? cpl_len_i : req_len_i;
                        tag_d     = grant_cpl ? 8'(cpl_tag_i) : 8'(req_tag_i);
                        addr_d    = req_addr_i;
                        rid_d     = cpl_req_id_i;
                        la_d      = cpl_lower_addr_i;
                        if (cpl_valid_i && req_valid_i)
                            prio_cpl_d = !prio_cpl_q;
                    end
                end
                HDR0: begin
                    tx_valid_o = 1'b1;
                    tx_sop_o   = 1'b1;
                    tx_data_o  = {src_cpl_q ? 8'h4A : (wr_q ? 8'h40 : 8'h00), 14'h0, len_q};
                    if (tx_ready_i)
                        state_d = HDR1;
                end
                HDR1: begin
                    tx_valid_o = 1'b1;
                    tx_data_o  = src_cpl_q ? {COMPLETER_ID, 4'h0, len_q, 2'b00}
                                           : {COMPLETER_ID, tag_q, (len_q == 10'd1) ? 4'h0 : 4'hF, 4'hF};
                    if (tx_ready_i)
                        state_d = HDR2;
                end
                HDR2: begin
                    tx_valid_o = 1'b1;
                    tx_eop_o   = !has_payload;
                    tx_data_o  = src_cpl_q ? {rid_q, tag_q, 1'b0, la_q} : (addr_q & 32'hFFFF_FFFC);
                    if (tx_ready_i)
                        state_d = has_payload ? PAYLOAD : IDLE;
                end
                PAYLOAD: begin
                    tx_valid_o       = src_valid;
                    tx_eop_o         = cnt_q == 10'd1;
                    tx_data_o        = src_cpl_q ? cpl_data_i : wr_data_i;
                    wr_data_ready_o  = !src_cpl_q && tx_ready_i;
                    cpl_data_ready_o = src_cpl_q && tx_ready_i;
                    if (src_valid && tx_ready_i) begin
                        cnt_d = cnt_q - 10'd1;
                        if (cnt_q == 10'd1)
                            state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and captured header registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_cpl_q <= 1'b1;
            src_cpl_q  <= 1'b0;
            wr_q       <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            tag_q      <= '0;
            addr_q     <= '0;
            rid_q      <= '0;
            la_q       <= '0;
        end else begin
            state_q    <= state_d;
            prio_cpl_q <= prio_cpl_d;
            src_cpl_q  <= src_cpl_d;
            wr_q       <= wr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
            addr_q     <= addr_d;
            rid_q      <= rid_d;
            la_q       <= la_d;
        end
    end
endmodule

// File: tb/tb_tl_tx_builder.sv
// tb_tl_tx_builder: scoreboard bench for the TLP transmit builder
module tb_tl_tx_builder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, req_ready_o, req_is_wr_i;
    logic [31:0] req_addr_i;
    logic [9:0]  req_len_i;
    logic [7:0]  req_tag_i;
    logic [31:0] wr_data_i;
    logic        wr_data_valid_i, wr_data_ready_o;
    logic        cpl_valid_i, cpl_ready_o;
    logic [7:0]  cpl_tag_i;
    logic [15:0] cpl_req_id_i;
    logic [9:0]  cpl_len_i;
    logic [6:0]  cpl_lower_addr_i;
    logic [31:0] cpl_data_i;
    logic        cpl_data_valid_i, cpl_data_ready_o;
    logic [31:0] tx_data_o;
    logic        tx_sop_o, tx_eop_o, tx_valid_o, tx_ready_i;

    int          checks = 0;
    int          errors = 0;
    logic [33:0] exp_q[$];
    bit          glog[$];
    bit          stall_prev = 0;
    logic [33:0] prev_beat;
    bit          wr_rdy_seen = 0;
    bit          prev_req_rdy = 0, prev_cpl_rdy = 0;
    bit          tog_en = 0;

    always #5 clk = ~clk;

    tl_tx_builder #(.TAG_W(8), .COMPLETER_ID(16'h0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_is_wr_i(req_is_wr_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_tag_i(req_tag_i),
        .wr_data_i(wr_data_i), .wr_data_valid_i(wr_data_valid_i), .wr_data_ready_o(wr_data_ready_o),
        .cpl_valid_i(cpl_valid_i), .cpl_ready_o(cpl_ready_o), .cpl_tag_i(cpl_tag_i),
        .cpl_req_id_i(cpl_req_id_i), .cpl_len_i(cpl_len_i), .cpl_lower_addr_i(cpl_lower_addr_i),
        .cpl_data_i(cpl_data_i), .cpl_data_valid_i(cpl_data_valid_i), .cpl_data_ready_o(cpl_data_ready_o),
        .tx_data_o(tx_data_o), .tx_sop_o(tx_sop_o), .tx_eop_o(tx_eop_o),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i)
    );

    // Monitor: scoreboard pops on every tx handshake, plus hold and ready-pulse checks
    always @(negedge clk) begin
        if (stall_prev) begin
            checks++;
            if (!tx_valid_o || {tx_sop_o, tx_eop_o, tx_data_o} !== prev_beat) begin
                errors++;
                $display("FAIL hold: got v=%0b sop/eop/data=%h required v=1 %h", tx_valid_o, {tx_sop_o, tx_eop_o, tx_data_o}, prev_beat);
            end
        end
        stall_prev = tx_valid_o && !tx_ready_i;
        prev_beat  = {tx_sop_o, tx_eop_o, tx_data_o};
        if (tx_valid_o && tx_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected sop=%0b eop=%0b data=%h, none required", tx_sop_o, tx_eop_o, tx_data_o);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                if ({tx_sop_o, tx_eop_o, tx_data_o} !== e)
                begin
                    errors++;
                    $display("FAIL beat: got sop=%0b eop=%0b data=%h required sop=%0b eop=%0b data=%h",
                             tx_sop_o, tx_eop_o, tx_data_o, e[33], e[32], e[31:0]);
                end
            end
        end
        if (wr_data_ready_o) wr_rdy_seen = 1;
        if (req_ready_o || cpl_ready_o) begin
            checks++;
            if ((req_ready_o && prev_req_rdy) || (cpl_ready_o && prev_cpl_rdy) || (req_ready_o && cpl_ready_o)) begin
                errors++;
                $display("FAIL ready_pulse: got req=%0b cpl=%0b (prev %0b %0b) required single one-cycle pulse",
                         req_ready_o, cpl_ready_o, prev_req_rdy, prev_cpl_rdy);
            end
            glog.push_back(cpl_ready_o);
        end
        prev_req_rdy = req_ready_o;
        prev_cpl_rdy = cpl_ready_o;
    end

    always @(posedge clk) begin
        #1 if (tog_en) tx_ready_i = ~tx_ready_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic exp_beat(input logic [31:0] d, input logic s, input logic e);
        exp_q.push_back({s, e, d});
    endtask

    task automatic wait_hs(input int which);
        bit got = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((which == 0 && req_ready_o) || (which == 1 && cpl_ready_o) ||
                (which == 2 && wr_data_ready_o) || (which == 3 && cpl_data_ready_o)) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout: handshake %0d got none required ready within 200 cycles", which);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic w, input logic [31:0] a, input logic [9:0] l, input logic [7:0] t);
        req_is_wr_i = w; req_addr_i = a; req_len_i = l; req_tag_i = t; req_valid_i = 1;
        wait_hs(0);
        req_valid_i = 0;
    endtask

    task automatic send_cpl(input logic [7:0] t, input logic [15:0] rid, input logic [9:0] l, input logic [6:0] la);
        cpl_tag_i = t; cpl_req_id_i = rid; cpl_len_i = l; cpl_lower_addr_i = la; cpl_valid_i = 1;
        wait_hs(1);
        cpl_valid_i = 0;
    endtask

    task automatic send_wr_data(input logic [31:0] base, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            wr_data_i = base + 32'(i + 1);
            wr_data_valid_i = 1;
            wait_hs(2);
            wr_data_valid_i = 0;
            if (i == gap) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_cpl_data(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            cpl_data_i = base + 32'(i + 1);
            cpl_data_valid_i = 1;
            wait_hs(3);
            cpl_data_valid_i = 0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int ng;
        rst_n = 0; tx_ready_i = 1;
        req_valid_i = 0; req_is_wr_i = 0; req_addr_i = 0; req_len_i = 0; req_tag_i = 0;
        wr_data_i = 0; wr_data_valid_i = 0;
        cpl_valid_i = 0; cpl_tag_i = 0; cpl_req_id_i = 0; cpl_len_i = 0; cpl_lower_addr_i = 0;
        cpl_data_i = 0; cpl_data_valid_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {tx_valid_o, tx_sop_o, tx_eop_o, tx_data_o, req_ready_o, cpl_ready_o, wr_data_ready_o, cpl_data_ready_o}, 64'd0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("idle_outs", {tx_valid_o, tx_sop_o, tx_eop_o, tx_data_o, req_ready_o, cpl_ready_o, wr_data_ready_o, cpl_data_ready_o}, 64'd0);
        @(posedge clk); #1;

        // Both sources held valid: cpl, req, cpl, req
        for (int k = 0; k < 2; k++) begin
            exp_beat(32'h4A000001, 1, 0); exp_beat(32'h01000004, 0, 0);
            exp_beat(32'h03000110, 0, 0); exp_beat(32'h11112222, 0, 1);
            exp_beat(32'h00000001, 1, 0); exp_beat(32'h0100020F, 0, 0);
            exp_beat(32'h30000008, 0, 1);
        end
        cpl_tag_i = 8'h01; cpl_req_id_i = 16'h0300; cpl_len_i = 10'd1; cpl_lower_addr_i = 7'h10;
        cpl_data_i = 32'h11112222; cpl_data_valid_i = 1;
        req_is_wr_i = 0; req_addr_i = 32'h3000_0008; req_len_i = 10'd1; req_tag_i = 8'h02;
        cpl_valid_i = 1; req_valid_i = 1;
        ng = 0;
        for (int n = 0; n < 300 && ng < 4; n++) begin
            @(negedge clk);
            if (req_ready_o || cpl_ready_o) ng++;
        end
        @(posedge clk); #1 cpl_valid_i = 0; req_valid_i = 0;
        drain();
        cpl_data_valid_i = 0;
        chk("grant_count", 64'(glog.size()), 64'd4);
        if (glog.size() == 4) chk("grant_order", {glog[0], glog[1], glog[2], glog[3]}, 64'b1010);
        glog.delete();

        // MWr len 2
        exp_beat(32'h40000002, 1, 0); exp_beat(32'h010005FF, 0, 0); exp_beat(32'h10000004, 0, 0);
        exp_beat(32'hAAAA0001, 0, 0); exp_beat(32'hAAAA0002, 0, 1);
        fork
            send_req(1, 32'h1000_0006, 10'd2, 8'd5);
            send_wr_data(32'hAAAA0000, 2, -1);
        join
        drain();

        // MRd len 1: write-data ready must stay low
        wr_rdy_seen = 0;
        exp_beat(32'h00000001, 1, 0); exp_beat(32'h0100030F, 0, 0); exp_beat(32'h20000000, 0, 1);
        send_req(0, 32'h2000_0000, 10'd1, 8'd3);
        drain();
        chk("mrd_wr_ready", 64'(wr_rdy_seen), 64'd0);

        // CplD len 1
        exp_beat(32'h4A000001, 1, 0); exp_beat(32'h01000004, 0, 0);
        exp_beat(32'h02000704, 0, 0); exp_beat(32'hDEADBEEF, 0, 1);
        fork
            send_cpl(8'd7, 16'h0200, 10'd1, 7'h04);
            send_cpl_data(32'hDEADBEEE, 1);
        join
        drain();

        // MWr len 4 with toggling tx_ready and a 2-cycle payload gap
        exp_beat(32'h40000004, 1, 0); exp_beat(32'h010009FF, 0, 0); exp_beat(32'h40000010, 0, 0);
        exp_beat(32'hB0000001, 0, 0); exp_beat(32'hB0000002, 0, 0);
        exp_beat(32'hB0000003, 0, 0); exp_beat(32'hB0000004, 0, 1);
        tog_en = 1;
        fork
            send_req(1, 32'h4000_0010, 10'd4, 8'd9);
            send_wr_data(32'hB0000000, 4, 1);
        join
        drain();
        tog_en = 0;
        @(posedge clk); #2 tx_ready_i = 1;

        // Reset during payload beat 2 of a len-4 CplD, then a clean MRd
        exp_beat(32'h4A000004, 1, 0); exp_beat(32'h01000010, 0, 0);
        exp_beat(32'h05000A08, 0, 0); exp_beat(32'hC0000001, 0, 0);
        fork
            send_cpl(8'h0A, 16'h0500, 10'd4, 7'h08);
            begin
                cpl_data_i = 32'hC0000001; cpl_data_valid_i = 1;
                wait_hs(3);
                cpl_data_i = 32'hC0000002; rst_n = 0;
                @(posedge clk); #1 rst_n = 1; cpl_data_valid_i = 0;
                @(negedge clk);
                chk("post_reset_outs", {tx_valid_o, tx_sop_o, tx_eop_o, cpl_data_ready_o, cpl_ready_o}, 64'd0);
            end
        join
        chk("reset_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        exp_beat(32'h00000001, 1, 0); exp_beat(32'h0100040F, 0, 0); exp_beat(32'h50000004, 0, 1);
        send_req(0, 32'h5000_0004, 10'd1, 8'd4);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tl_tx_builder.md
Name: tl_tx_builder

Overview:
- Transmit-side TLP builder for the transaction layer; counterpart of the RX parser on the DLL stream.
- Accepts user memory requests (MWr/MRd) and completer-side completions (CplD), round-robin arbitrates them, and serialises each packet onto a 32-bit DW stream toward the DLL.
- Output order is 3-DW header, then payload when present, with sop/eop framing.

Parameters:
- TAG_W, 8, tag width; legal range 1..8; zero-extended to 8 bits in headers.
- COMPLETER_ID, 16'h0100, bus/dev/fn ID used as requester ID (requests) and completer ID (CplD).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid_i  in  1  request header valid
- req_ready_o  out  1  request header accepted
- req_is_wr_i  in  1  1=MWr, 0=MRd
- req_addr_i  in  32  byte address; bits[1:0] forced to 0 in header
- req_len_i  in  10  length in DW; 0 means 1024
- req_tag_i  in  TAG_W  request tag
- wr_data_i  in  32  MWr payload DW
- wr_data_valid_i  in  1  MWr payload valid
- wr_data_ready_o  out  1  MWr payload accepted
- cpl_valid_i  in  1  completion header valid
- cpl_ready_o  out  1  completion header accepted
- cpl_tag_i  in  TAG_W  tag of the original request
- cpl_req_id_i  in  16  requester ID of the original request
- cpl_len_i  in  10  payload DW; 0 means 1024
- cpl_lower_addr_i  in  7  lower address field
- cpl_data_i  in  32  CplD payload DW
- cpl_data_valid_i  in  1  CplD payload valid
- cpl_data_ready_o  out  1  CplD payload accepted
- tx_data_o  out  32  DW to DLL
- tx_sop_o  out  1  first DW of packet
- tx_eop_o  out  1  last DW of packet
- tx_valid_o  out  1  tx beat valid
- tx_ready_i  in  1  DLL accepts beat

Behaviour:
- Reset: all outputs 0; FSM=IDLE; round-robin priority set to completion.
- FSM: IDLE -> HDR0 -> HDR1 -> HDR2 -> PAYLOAD (MWr/CplD) or IDLE (MRd).
  - Header states advance only on tx_valid_o && tx_ready_i.
  - PAYLOAD returns to IDLE after the last beat.
- IDLE arbitration:
  - Only one valid: grant it.
  - Both valid: grant the priority holder, then give priority to the other source.
  - In the grant cycle, assert req_ready_o or cpl_ready_o for exactly one cycle and capture the header fields into registers.
  - Neither ready is asserted outside IDLE.
- Latency: DW0 is presented on tx_* in the cycle after the grant. One IDLE cycle separates packets.
- Header encoding:
  - MWr DW0 = 0x40 in [31:24], [23:10]=0, [9:0]=len.
  - MRd DW0 = 0x00 in [31:24], [23:10]=0, [9:0]=len.
  - CplD DW0 = 0x4A in [31:24], [23:10]=0, [9:0]=len.
  - Request DW1 = {COMPLETER_ID, tag8, lastBE, firstBE}; firstBE=4'hF; lastBE=4'h0 if len==1, else 4'hF.
  - Request DW2 = {addr[31:2], 2'b00}.
  - CplD DW1 = {COMPLETER_ID, status 3'b000, BCM 1'b0, byte_count[11:0]}; byte_count = len*4 mod 4096, so len 0 gives 12'h000.
  - CplD DW2 = {req_id, tag8, 1'b0, lower_addr}.
- Framing:
  - tx_sop_o=1 on HDR0 only.
  - tx_eop_o=1 on HDR2 for MRd, otherwise on the final payload beat.
- PAYLOAD:
  - Pass-through from the granted source: tx_valid_o = src_valid, src_ready = tx_ready_i, tx_data_o = src_data.
  - The non-granted data ready stays 0.
  - A 10-bit beat counter loads len, where 0 means 1024, and decrements on each handshake; the last beat is at count 1.
- Backpressure:
  - While tx_valid_o && !tx_ready_i, tx_data_o, tx_sop_o and tx_eop_o are held stable.
  - A source payload stall drives tx_valid_o low; no bubble data is emitted.
- Extra payload beats offered after the last beat are not accepted; ready=0 until the next grant.
- Reset mid-packet: returns to IDLE next edge with outputs 0. The partial packet is abandoned without eop, and the next packet starts with sop.

Test Plan:
- MWr addr 0x1000_0006, len 2, tag 5, data 0xAAAA0001/0xAAAA0002 -> beats 0x40000002(sop), 0x010005FF, 0x10000004, 0xAAAA0001, 0xAAAA0002(eop).
- MRd addr 0x2000_0000, len 1, tag 3 -> beats 0x00000001(sop), 0x0100030F, 0x20000000(eop); wr_data_ready_o never 1.
- CplD tag 7, req_id 0x0200, len 1, lower_addr 0x04, data 0xDEADBEEF -> 0x4A000001, 0x01000004, 0x02000704, 0xDEADBEEF(eop).
- Both valid after reset, held for 4 packets -> grant order cpl, req, cpl, req; each ready is a one-cycle pulse.
- tx_ready_i toggles every cycle during a 4-DW MWr and wr_data_valid_i drops for 2 cycles mid-payload -> exact 7-beat sequence, no duplicate or dropped DW, held data stable while stalled.
- rst_n low for 1 cycle during payload beat 2 of a len-4 CplD -> next cycle tx_valid_o=0 and FSM=IDLE; a new MRd then emits a clean 3-beat packet starting with sop.
